// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined reduction adder tree.
//   level_width  : operand width entering adder layer L
//   num_stages   : number of register stages for a given layer count and grouping
//   stage_layers : adder layers packed into register stage k
//   stage_inputs : operand count entering register stage k
//   is_pow2      : power-of-two test used for parameter checking
package adder_tree_pkg;

  function automatic int level_width(input int data_w, input int level);
    return data_w + level;
  endfunction

  function automatic int num_stages(input int levels, input int pipe_every);
    return (levels + pipe_every - 1) / pipe_every;
  endfunction

  // Every stage holds pipe_every layers except possibly the last, which takes
  // whatever remains so that the final layer always ends in a register.
  function automatic int stage_layers(input int levels, input int pipe_every, input int k);
    int remaining;
    remaining = levels - k * pipe_every;
    return (remaining < pipe_every) ? remaining : pipe_every;
  endfunction

  function automatic int stage_inputs(input int inputs, input int pipe_every, input int k);
    return inputs >> (k * pipe_every);
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One register stage of the reduction tree: N_LAYERS combinational pairwise
// layers followed by a single register slice carrying data, mode and valid.
//   clk, rst    : clock, synchronous active-high reset
//   load        : slice captures this cycle (computed by the parent from the
//                 downstream ready chain)
//   src_valid   : incoming vector valid
//   src_signed  : incoming mode bit (1 = two's complement operands)
//   src_data    : N_IN operands of IN_W bits
//   vld, sgn    : registered valid and mode bit
//   data        : N_IN>>N_LAYERS partial sums of IN_W+N_LAYERS bits
module adder_tree_stage
  import adder_tree_pkg::*;
#(
  parameter int N_IN     = 8,
  parameter int IN_W     = 8,
  parameter int N_LAYERS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     src_valid,
  input  logic                     src_signed,
  input  logic [IN_W-1:0]          src_data [N_IN],
  output logic                     vld,
  output logic                     sgn,
  output logic [IN_W+N_LAYERS-1:0] data [N_IN>>N_LAYERS]
);

  localparam int N_OUT = N_IN >> N_LAYERS;
  localparam int OUT_W = level_width(IN_W, N_LAYERS);

  // ---- combinational layers --------------------------------------------
  for (genvar l = 0; l < N_LAYERS; l++) begin : g_layer
    localparam int W = level_width(IN_W, l);
    localparam int N = N_IN >> l;

    logic [W-1:0] opnd [N];
    logic [W:0]   sum  [N/2];

    if (l == 0) begin : g_src_in
      assign opnd = src_data;
    end else begin : g_src_prev
      assign opnd = g_layer[l-1].sum;
    end

    for (genvar i = 0; i < N/2; i++) begin : g_pair
      logic signed [W:0] a_ext;
      logic signed [W:0] b_ext;
      // One guard bit per layer keeps the sum exact in both modes.
      assign a_ext  = {src_signed & opnd[2*i][W-1],   opnd[2*i]};
      assign b_ext  = {src_signed & opnd[2*i+1][W-1], opnd[2*i+1]};
      assign sum[i] = a_ext + b_ext;
    end
  end

  logic [OUT_W-1:0] sum_c [N_OUT];
  assign sum_c = g_layer[N_LAYERS-1].sum;

  // ---- register slice (p0) ----------------------------------------------
  logic             vld_p0;
  logic             sgn_p0;
  logic [OUT_W-1:0] data_p0 [N_OUT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      sgn_p0 <= 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
        data_p0[i] <= '0;
      end
    end else if (load) begin
      vld_p0 <= src_valid;
      // Payload only moves with a real vector, so a stalled or idle slice
      // keeps its last result stable.
      if (src_valid) begin
        sgn_p0  <= src_signed;
        data_p0 <= sum_c;
      end
    end
  end

  assign vld  = vld_p0;
  assign sgn  = sgn_p0;
  assign data = data_p0;

endmodule

// File: rtl/adder_tree_pipelined.sv
// Pipelined, mode-aware reduction adder tree with valid/ready flow control.
// Sums INPUTS_AMOUNT operands of DATAW bits into one exact OUTW-bit result,
// registering after every PIPE_EVERY adder layers (the last layer is always
// registered). Latency is STAGES cycles; throughput one vector per cycle.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   in_valid_i    : input vector valid
//   in_ready_o    : tree accepts the vector this cycle (0 during reset)
//   in_signed_i   : 1 = two's complement operands, 0 = unsigned
//   in_data_i     : INPUTS_AMOUNT operands
//   out_valid_o   : result valid
//   out_ready_i   : downstream accepts the result
//   out_signed_o  : mode bit travelling with the result
//   out_data_o    : reduced sum
module adder_tree_pipelined
  import adder_tree_pkg::*;
#(
  parameter int  INPUTS_AMOUNT = 8,
  parameter int  DATAW         = 8,
  parameter int  PIPE_EVERY    = 1,
  localparam int LEVELS        = $clog2(INPUTS_AMOUNT),
  localparam int STAGES        = num_stages(LEVELS, PIPE_EVERY),
  localparam int OUTW          = level_width(DATAW, LEVELS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_signed_i,
  input  logic [DATAW-1:0] in_data_i [INPUTS_AMOUNT],
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_signed_o,
  output logic [OUTW-1:0]  out_data_o
);

  if (INPUTS_AMOUNT < 2 || !is_pow2(INPUTS_AMOUNT)) begin : g_bad_inputs
    $fatal(1, "adder_tree_pipelined: INPUTS_AMOUNT must be a power of two >= 2");
  end

  if (PIPE_EVERY < 1 || PIPE_EVERY > LEVELS) begin : g_bad_pipe
    $fatal(1, "adder_tree_pipelined: PIPE_EVERY must lie in 1..LEVELS");
  end

  logic              stg_vld [STAGES];
  logic              stg_sgn [STAGES];
  logic [STAGES-1:0] ld_v;

  // A slice may load when it is empty or its contents move on this cycle.
  // Resolving the chain from the output back lets a downstream transfer free
  // every full slice behind it in the same cycle (bubble collapsing).
  always_comb begin
    logic ripple;
    ld_v   = '0;
    ripple = out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ripple  = !stg_vld[k] || ripple;
      ld_v[k] = ripple;
    end
  end

  assign in_ready_o = ld_v[0] && !rst_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int NL   = stage_layers(LEVELS, PIPE_EVERY, k);
    localparam int N_IN = stage_inputs(INPUTS_AMOUNT, PIPE_EVERY, k);
    localparam int IN_W = level_width(DATAW, k * PIPE_EVERY);

    logic [IN_W-1:0]    stg_in  [N_IN];
    logic [IN_W+NL-1:0] stg_out [N_IN>>NL];
    logic               src_valid;
    logic               src_signed;

    // ---- stage boundary k: input side fed by the ports or stage k-1 ----
    if (k == 0) begin : g_head
      assign stg_in     = in_data_i;
      assign src_valid  = in_valid_i;
      assign src_signed = in_signed_i;
    end else begin : g_body
      assign stg_in     = g_stage[k-1].stg_out;
      assign src_valid  = stg_vld[k-1];
      assign src_signed = stg_sgn[k-1];
    end

    adder_tree_stage #(
      .N_IN     (N_IN),
      .IN_W     (IN_W),
      .N_LAYERS (NL)
    ) u_stage (
      .clk        (clk_i),
      .rst        (rst_i),
      .load       (ld_v[k]),
      .src_valid  (src_valid),
      .src_signed (src_signed),
      .src_data   (stg_in),
      .vld        (stg_vld[k]),
      .sgn        (stg_sgn[k]),
      .data       (stg_out)
    );
  end

  // ---- output boundary: last slice drives the result ports --------------
  assign out_valid_o  = stg_vld[STAGES-1];
  assign out_signed_o = stg_sgn[STAGES-1];
  assign out_data_o   = g_stage[STAGES-1].stg_out[0];

endmodule
